// File: rtl/maroc_sc_sequencer.sv
// MAROC slow-control load sequencer: accepts a frame, resets and starts the serial
// transmitter, optionally re-shifts to capture the chip echo, and retries on mismatch.
module maroc_sc_sequencer #(
  parameter int FRAME_BITS = 829,
  parameter int RST_CYCLES = 4,
  parameter int GAP_CYCLES = 8,
  parameter int MAX_RETRY  = 3,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FRAME_BITS-1:0] cfg_frame,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic                  verify_en,
  output logic                  tx_rst,
  output logic                  tx_start,
  output logic [FRAME_BITS-1:0] tx_frame,
  input  logic                  tx_bit_stb,
  input  logic                  q_sc,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [3:0]            retry_cnt
);

  localparam int BW     = $clog2(FRAME_BITS);
  localparam int WW     = $clog2(TIMEOUT + 1);
  localparam int DW_MAX = (RST_CYCLES > GAP_CYCLES) ? RST_CYCLES : GAP_CYCLES;
  localparam int CW     = $clog2(DW_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_START, S_SHIFT, S_GAP, S_CHECK, S_DONE, S_FAIL
  } state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [WW-1:0]         wd_q, wd_d;
  logic [CW-1:0]         cyc_q, cyc_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [FRAME_BITS-1:0] cap_q, cap_d;
  logic                  verify_q, verify_d;
  logic                  pass2_q, pass2_d;
  logic                  error_q, error_d;
  logic [3:0]            retry_q, retry_d;

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    wd_d     = wd_q;
    cyc_d    = cyc_q;
    frame_d  = frame_q;
    cap_d    = cap_q;
    verify_d = verify_q;
    pass2_d  = pass2_q;
    error_d  = error_q;
    retry_d  = retry_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          frame_d  = cfg_frame;
          verify_d = verify_en;
          retry_d  = 4'd0;
          error_d  = 1'b0;
          pass2_d  = 1'b0;
          cyc_d    = '0;
          state_d  = S_RST;
        end
      end
      S_RST: begin
        if (cyc_q == CW'(RST_CYCLES - 1)) begin
          cyc_d   = '0;
          state_d = S_START;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_START: begin
        bit_d   = '0;
        wd_d    = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (tx_bit_stb) begin
          wd_d = '0;
          // Echo enters at the MSB so the first echoed bit ends up in bit 0.
          if (pass2_q) cap_d = {q_sc, cap_q[FRAME_BITS-1:1]};
          if (bit_q == BW'(FRAME_BITS - 1)) begin
            if (pass2_q) begin
              state_d = S_CHECK;
            end else if (verify_q) begin
              cyc_d   = '0;
              state_d = S_GAP;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          wd_d = wd_q + 1'b1;
          if (wd_d == WW'(TIMEOUT)) begin
            error_d = 1'b1;
            state_d = S_FAIL;
          end
        end
      end
      S_GAP: begin
        if (cyc_q == CW'(GAP_CYCLES - 1)) begin
          cyc_d   = '0;
          pass2_d = 1'b1;
          state_d = S_RST;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (cap_q == frame_q) begin
          state_d = S_DONE;
        end else if (retry_q < 4'(MAX_RETRY)) begin
          retry_d = retry_q + 1'b1;
          pass2_d = 1'b0;
          cyc_d   = '0;
          state_d = S_RST;
        end else begin
          error_d = 1'b1;
          state_d = S_FAIL;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bit_q    <= '0;
      wd_q     <= '0;
      cyc_q    <= '0;
      frame_q  <= '0;
      cap_q    <= '0;
      verify_q <= 1'b0;
      pass2_q  <= 1'b0;
      error_q  <= 1'b0;
      retry_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      wd_q     <= wd_d;
      cyc_q    <= cyc_d;
      frame_q  <= frame_d;
      cap_q    <= cap_d;
      verify_q <= verify_d;
      pass2_q  <= pass2_d;
      error_q  <= error_d;
      retry_q  <= retry_d;
    end
  end

  assign cfg_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign tx_rst    = (state_q == S_RST);
  assign tx_start  = (state_q == S_START);
  assign done      = (state_q == S_DONE);
  assign error     = error_q;
  assign retry_cnt = retry_q;
  assign tx_frame  = frame_q;

endmodule

// File: tb/tb_maroc_sc_sequencer.sv
// Randomized bench for maroc_sc_sequencer with a behavioural transmitter/chip model
// and a pass-count outcome model.
module tb_maroc_sc_sequencer;
  localparam int FB = 829;
  localparam int RC = 4;
  localparam int GC = 8;
  localparam int MR = 3;
  localparam int TO = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic [FB-1:0] cfg_frame;
  logic          cfg_valid, cfg_ready, verify_en;
  logic          tx_rst, tx_start, tx_bit_stb, q_sc;
  logic [FB-1:0] tx_frame;
  logic          busy, done, error;
  logic [3:0]    retry_cnt;

  maroc_sc_sequencer #(
    .FRAME_BITS(FB), .RST_CYCLES(RC), .GAP_CYCLES(GC), .MAX_RETRY(MR), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .cfg_frame(cfg_frame), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .verify_en(verify_en), .tx_rst(tx_rst), .tx_start(tx_start),
    .tx_frame(tx_frame), .tx_bit_stb(tx_bit_stb), .q_sc(q_sc), .busy(busy),
    .done(done), .error(error), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Transmitter/chip model controls and observations
  logic [FB-1:0] frame_ref = '0;
  bit verify_ref = 0, stray_start_stb = 0, tx_abort = 0, active = 0;
  int mode = 0, flip_bit = 0, period = 1, stop_after = FB;
  int nc = 0, starts = 0, dones = 0, rst_seen = 0, bits_sent = 0, gap_cnt = 0;
  int last_stb_nc = 0, p1_last_nc = 0, done_nc = 0, first_start_nc = 0, second_start_nc = 0;

  function automatic bit echo_bit(input int k);
    bit b;
    int vp;
    b = frame_ref[k];
    if (verify_ref && (starts % 2 == 0)) begin
      vp = starts / 2;
      if (mode == 2 && k == flip_bit) b = ~b;
      if (mode == 1 && vp == 1 && k == flip_bit) b = ~b;
    end
    return b;
  endfunction

  initial begin
    tx_bit_stb = 1'b0;
    q_sc = 1'b0;
    forever begin
      @(negedge clk);
      nc++;
      tx_bit_stb = 1'b0;
      q_sc = 1'b0;
      if (tx_rst) rst_seen++;
      if (done) begin
        dones++;
        done_nc = nc;
      end
      if (tx_abort) begin
        active = 0;
      end else if (active) begin
        if (gap_cnt > 0) begin
          gap_cnt--;
        end else if (bits_sent < stop_after) begin
          tx_bit_stb = 1'b1;
          q_sc = echo_bit(bits_sent);
          bits_sent++;
          gap_cnt = period - 1;
          last_stb_nc = nc;
          if (bits_sent == FB) begin
            active = 0;
            if (starts == 1) p1_last_nc = nc;
          end
        end
      end
      if (tx_start) begin
        starts++;
        if (starts == 1) first_start_nc = nc;
        if (starts == 2) second_start_nc = nc;
        active = 1;
        bits_sent = 0;
        gap_cnt = 0;
        if (stray_start_stb) begin
          tx_bit_stb = 1'b1;
          q_sc = 1'b1;
        end
      end
    end
  end

  // Outcome derived from the pass/retry rules
  task automatic expect_outcome(input bit v, input int m, input bit stalled,
                                output int e_starts, output int e_done,
                                output int e_err, output int e_retry);
    if (stalled) begin
      e_starts = 1; e_done = 0; e_err = 1; e_retry = 0;
    end else if (!v || m == 0) begin
      e_starts = v ? 2 : 1; e_done = 1; e_err = 0; e_retry = 0;
    end else if (m == 1) begin
      e_starts = 4; e_done = 1; e_err = 0; e_retry = 1;
    end else begin
      e_starts = 2 * (MR + 1); e_done = 0; e_err = 1; e_retry = MR;
    end
  endtask

  function automatic logic [FB-1:0] rand_frame();
    logic [FB-1:0] f;
    for (int i = 0; i < FB; i++) f[i] = 1'($urandom_range(0, 1));
    return f;
  endfunction

  task automatic launch(input logic [FB-1:0] f, input bit v, input int m, input int per,
                        input int stop, input bit stray, input string name, output int acc);
    frame_ref = f; verify_ref = v; mode = m; period = per; stop_after = stop;
    stray_start_stb = stray;
    starts = 0; dones = 0; rst_seen = 0; last_stb_nc = 0; p1_last_nc = 0; done_nc = 0;
    cfg_frame = f; verify_en = v; cfg_valid = 1'b1;
    acc = nc;
    @(negedge clk); #1;
    cfg_valid = 1'b0;
    verify_en = ~v;
    cfg_frame = ~f;
    check_val({name, ".ready_drop"}, cfg_ready, 0);
    check_val({name, ".busy"}, busy, 1);
    check_val({name, ".frame_latched"}, longint'(tx_frame == f), 1);
  endtask

  task automatic run_seq(input logic [FB-1:0] f, input bit v, input int m, input int per,
                         input int stop, input bit stray, input string name);
    int acc, w, idle_nc, es, ed, ee, er, d;
    launch(f, v, m, per, stop, stray, name, acc);
    w = 0;
    while (busy && w < 40000) begin
      @(negedge clk); #1;
      w++;
    end
    idle_nc = nc;
    check_val({name, ".finished"}, busy, 0);
    expect_outcome(v, m, stop < FB, es, ed, ee, er);
    check_val({name, ".starts"}, starts, es);
    check_val({name, ".done"}, dones, ed);
    check_val({name, ".error"}, error, ee);
    check_val({name, ".retry"}, retry_cnt, er);
    check_val({name, ".ready"}, cfg_ready, 1);
    check_val({name, ".txrst_cycles"}, rst_seen, es * RC);
    check_val({name, ".start_lat"}, first_start_nc - acc, RC + 1);
    check_val({name, ".frame_kept"}, longint'(tx_frame == f), 1);
    if (ed == 1) check_val({name, ".done_lat"}, done_nc - last_stb_nc, v ? 2 : 1);
    if (v && stop == FB) check_val({name, ".gap"}, second_start_nc - p1_last_nc, GC + RC + 1);
    if (stop < FB) begin
      d = idle_nc - last_stb_nc;
      check_val({name, ".wd_time"}, longint'(d >= TO && d <= TO + 4), 1);
    end
  endtask

  initial begin
    logic [FB-1:0] f;
    int acc, w;
    rst = 1'b1; cfg_valid = 1'b0; cfg_frame = '0; verify_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("reset.busy", busy, 0);
    check_val("reset.ready", cfg_ready, 1);
    check_val("reset.txrst", tx_rst, 0);
    check_val("reset.txstart", tx_start, 0);
    check_val("reset.error", error, 0);
    check_val("reset.retry", retry_cnt, 0);
    check_val("reset.frame", longint'(tx_frame == '0), 1);
    rst = 1'b0;
    @(negedge clk); #1;

    for (int i = 0; i < FB; i++) f[i] = 1'(i % 2);
    run_seq(f, 0, 0, 2, FB, 1, "T1");
    run_seq(rand_frame(), 1, 0, 1, FB, 1, "T2");
    flip_bit = 400;
    run_seq(rand_frame(), 1, 1, 1, FB, 0, "T3");
    flip_bit = $urandom_range(0, FB - 1);
    run_seq(rand_frame(), 1, 2, 1, FB, 0, "T4");
    run_seq(rand_frame(), 0, 0, 1, 100, 0, "T5");

    // rst and cfg_valid together: frame must not be accepted
    rst = 1'b1; cfg_valid = 1'b1; cfg_frame = rand_frame();
    @(negedge clk); #1;
    rst = 1'b0; cfg_valid = 1'b0;
    check_val("rstvalid.busy", busy, 0);
    check_val("rstvalid.frame", longint'(tx_frame == '0), 1);
    check_val("rstvalid.error", error, 0);
    @(negedge clk); #1;
    check_val("rstvalid.busy2", busy, 0);

    // T6: reset during the shift
    launch(rand_frame(), 1, 0, 1, FB, 0, "T6", acc);
    w = 0;
    while (bits_sent < 500 && w < 5000) begin
      @(negedge clk); #1;
      w++;
    end
    check_val("T6.reached500", longint'(bits_sent >= 500), 1);
    rst = 1'b1; tx_abort = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    check_val("T6.busy", busy, 0);
    check_val("T6.ready", cfg_ready, 1);
    check_val("T6.txstart", tx_start, 0);
    check_val("T6.txrst", tx_rst, 0);
    check_val("T6.error", error, 0);
    check_val("T6.done", done, 0);
    @(negedge clk); #1;
    tx_abort = 1'b0;
    run_seq(rand_frame(), 0, 0, 1, FB, 0, "T6b");

    for (int r = 0; r < 4; r++) begin
      flip_bit = $urandom_range(0, FB - 1);
      run_seq(rand_frame(), 1'($urandom_range(0, 1)), $urandom_range(0, 1),
              $urandom_range(1, 2), FB, 1'($urandom_range(0, 1)), $sformatf("R%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
